// File: rtl/udp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : udp_pkg
//  Description : Shared constants and FSM state encodings for the UDP receive
//                payload buffer and its helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package udp_pkg;

    // Largest UDP payload carried in a single 1500-byte Ethernet MTU
    localparam int MAX_UDP_PAYLOAD = 1472;
    // Width of a frame-length word (covers 0..2047)
    localparam int LEN_W           = 11;

    // Write-side (capture) states
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RECV = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

    // Read-side (replay) states
    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/udp_len_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : udp_len_fifo
//  Description : Small synchronous show-ahead FIFO holding committed frame
//                lengths. DEPTH must be a power of two, at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module udp_len_fifo
    import udp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Extra pointer bit distinguishes full from empty when low bits match
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[c_AW-1:0]];

    // Storage array; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
        end
    end

    // Pointer update; push and pop in the same cycle both take effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/udp_rx_buf.sv
`default_nettype none
// ============================================================================
//  Module      : udp_rx_buf
//  Description : Whole-frame payload buffer behind the UDP receive parser.
//                Bytes land in a circular RAM; frames are committed on done
//                or dropped atomically, then replayed one frame per request.
//  Revision    : 1.0 - initial release
// ============================================================================
module udp_rx_buf
    import udp_pkg::*;
#(
    parameter int DEPTH          = 4096,
    parameter int LEN_FIFO_DEPTH = 4,
    parameter int MAX_LEN        = MAX_UDP_PAYLOAD
) (
    input  logic        gmii_rxc,
    input  logic        rst_n,
    input  logic [7:0]  udp_rx_data,
    input  logic        udp_rx_data_en,
    input  logic        udp_rx_done,
    output logic        frame_ready,
    output logic [10:0] frame_len,
    input  logic        rd_start,
    output logic [7:0]  rd_data,
    output logic        rd_data_en,
    output logic        rd_done,
    output logic [15:0] drop_cnt
);

    localparam int               c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_RAM_SIZE = (c_AW+1)'(DEPTH);
    localparam logic [LEN_W-1:0] c_MAX_LEN  = LEN_W'(MAX_LEN);

    // ---------------- write side ----------------
    wr_state_t        r_wr_state, w_wr_nxt;
    logic [c_AW:0]    r_wr_ptr, r_commit_ptr, r_rd_base;
    logic [c_AW:0]    w_used;
    logic             w_ram_full, w_fifo_full, w_fifo_empty;
    logic [LEN_W-1:0] r_cur_len, w_push_len, w_head_len;
    logic             w_wr_en, w_push, w_rewind, w_drop_inc;
    logic [7:0]       r_mem [DEPTH];

    // Free space is measured against rd_base so in-flight replays stay safe
    assign w_used     = r_wr_ptr - r_rd_base;
    assign w_ram_full = (w_used == c_RAM_SIZE);

    // Write FSM next state and per-byte decisions
    always_comb begin
        w_wr_nxt   = r_wr_state;
        w_wr_en    = 1'b0;
        w_push     = 1'b0;
        w_push_len = r_cur_len;
        w_rewind   = 1'b0;
        w_drop_inc = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (udp_rx_data_en) begin
                    if (w_fifo_full || w_ram_full) begin
                        if (udp_rx_done) w_drop_inc = 1'b1;
                        else             w_wr_nxt   = W_DROP;
                    end else begin
                        w_wr_en = 1'b1;
                        if (udp_rx_done) begin
                            w_push     = 1'b1;
                            w_push_len = LEN_W'(1);
                        end else begin
                            w_wr_nxt = W_RECV;
                        end
                    end
                end
            end
            W_RECV: begin
                if (udp_rx_data_en && (w_ram_full || r_cur_len == c_MAX_LEN)) begin
                    w_rewind = 1'b1;
                    if (udp_rx_done) begin
                        w_drop_inc = 1'b1;
                        w_wr_nxt   = W_IDLE;
                    end else begin
                        w_wr_nxt = W_DROP;
                    end
                end else begin
                    w_wr_en = udp_rx_data_en;
                    if (udp_rx_done) begin
                        w_push     = 1'b1;
                        w_push_len = udp_rx_data_en ? r_cur_len + 1'b1 : r_cur_len;
                        w_wr_nxt   = W_IDLE;
                    end
                end
            end
            W_DROP: begin
                if (udp_rx_done) begin
                    w_rewind   = 1'b1;
                    w_drop_inc = 1'b1;
                    w_wr_nxt   = W_IDLE;
                end
            end
            default: w_wr_nxt = W_IDLE;
        endcase
    end

    // Write FSM state, pointers, running length and drop counter
    always_ff @(posedge gmii_rxc or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state   <= W_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_cur_len    <= '0;
            drop_cnt     <= '0;
        end else begin
            r_wr_state <= w_wr_nxt;
            if (w_rewind)     r_wr_ptr <= r_commit_ptr;
            else if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_push)       r_commit_ptr <= w_wr_en ? r_wr_ptr + 1'b1 : r_wr_ptr;
            if (w_wr_en)      r_cur_len <= (r_wr_state == W_IDLE) ? LEN_W'(1) : r_cur_len + 1'b1;
            if (w_drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // ---------------- read side ----------------
    rd_state_t        r_rd_state, w_rd_nxt;
    logic [c_AW:0]    r_rd_ptr, w_rd_addr;
    logic [LEN_W-1:0] r_rd_len, r_rd_remain;
    logic             w_rd_issue, w_rd_last, w_rd_accept;
    logic             r_ram_vld, r_ram_last;
    logic [7:0]       r_ram_q;

    // Pipeline stages still carrying a frame keep the next one hidden
    assign frame_ready = !w_fifo_empty && (r_rd_state == R_IDLE) && !r_ram_vld && !rd_data_en;
    assign frame_len   = frame_ready ? w_head_len : '0;

    // Read FSM next state; first read issues in the accept cycle
    always_comb begin
        w_rd_nxt    = r_rd_state;
        w_rd_issue  = 1'b0;
        w_rd_accept = 1'b0;
        w_rd_last   = 1'b0;
        w_rd_addr   = r_rd_ptr;
        case (r_rd_state)
            R_IDLE: begin
                if (rd_start && frame_ready) begin
                    w_rd_accept = 1'b1;
                    w_rd_issue  = 1'b1;
                    w_rd_addr   = r_rd_base;
                    w_rd_last   = (w_head_len == LEN_W'(1));
                    if (!w_rd_last) w_rd_nxt = R_READ;
                end
            end
            R_READ: begin
                w_rd_issue = 1'b1;
                w_rd_last  = (r_rd_remain == LEN_W'(1));
                if (w_rd_last) w_rd_nxt = R_IDLE;
            end
            default: w_rd_nxt = R_IDLE;
        endcase
    end

    // Inferred simple dual-port RAM: synchronous write and registered read
    always_ff @(posedge gmii_rxc) begin
        if (w_wr_en)    r_mem[r_wr_ptr[c_AW-1:0]] <= udp_rx_data;
        if (w_rd_issue) r_ram_q <= r_mem[w_rd_addr[c_AW-1:0]];
    end

    // Read FSM, replay pointers, output register and space release on done
    always_ff @(posedge gmii_rxc or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state  <= R_IDLE;
            r_rd_ptr    <= '0;
            r_rd_base   <= '0;
            r_rd_len    <= '0;
            r_rd_remain <= '0;
            r_ram_vld   <= 1'b0;
            r_ram_last  <= 1'b0;
            rd_data     <= '0;
            rd_data_en  <= 1'b0;
            rd_done     <= 1'b0;
        end else begin
            r_rd_state <= w_rd_nxt;
            if (w_rd_accept) begin
                r_rd_len    <= w_head_len;
                r_rd_ptr    <= r_rd_base + 1'b1;
                r_rd_remain <= w_head_len - 1'b1;
            end else if (w_rd_issue) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_rd_remain <= r_rd_remain - 1'b1;
            end
            r_ram_vld  <= w_rd_issue;
            r_ram_last <= w_rd_issue && w_rd_last;
            if (r_ram_vld) rd_data <= r_ram_q;
            rd_data_en <= r_ram_vld;
            rd_done    <= r_ram_vld && r_ram_last;
            if (rd_done) r_rd_base <= r_rd_base + (c_AW+1)'(r_rd_len);
        end
    end

    udp_len_fifo #(
        .DEPTH (LEN_FIFO_DEPTH),
        .WIDTH (LEN_W)
    ) u_len_fifo (
        .clk         (gmii_rxc),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_len),
        .i_pop       (rd_done),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_head_len)
    );

endmodule
`default_nettype wire
